// File: rtl/reg_file_sb.sv
// Multi-port register file with a pending-write scoreboard: two writeback ports,
// combinational reads with optional same-cycle forwarding, and per-register busy flags.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*ADDR_W-1:0]  readAddr,
  output logic [NREAD*DATA_W-1:0]  readData,
  output logic [NREAD-1:0]         readBusy,
  input  logic                     wrEn0,
  input  logic [ADDR_W-1:0]        wrAddr0,
  input  logic [DATA_W-1:0]        wrData0,
  input  logic                     wrEn1,
  input  logic [ADDR_W-1:0]        wrAddr1,
  input  logic [DATA_W-1:0]        wrData1,
  input  logic                     issueEn,
  input  logic [ADDR_W-1:0]        issueAddr,
  input  logic                     flush,
  output logic                     wrCollision,
  output logic [ADDR_W:0]          busyCnt
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;

  // Busy vector has bit 0 permanently clear, so the count tops out at DEPTH-1.
  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign wr0_ok = wrEn0 && (wrAddr0 != {ADDR_W{1'b0}});
  assign wr1_ok = wrEn1 && (wrAddr1 != {ADDR_W{1'b0}});

  // Register array; port 1 is written last so it wins on a shared address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_ok) begin
        regs[wrAddr0] <= wrData0;
      end
      if (wr1_ok) begin
        regs[wrAddr1] <= wrData1;
      end
    end
  end

  // Scoreboard next state: flush, then issue, then write-clear, else hold
  always_comb begin
    busy_next = busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (flush) begin
        busy_next[r] = 1'b0;
      end else if (issueEn && (issueAddr == ADDR_W'(r))) begin
        busy_next[r] = 1'b1;
      end else if ((wr0_ok && (wrAddr0 == ADDR_W'(r))) ||
                   (wr1_ok && (wrAddr1 == ADDR_W'(r)))) begin
        busy_next[r] = 1'b0;
      end else begin
        busy_next[r] = busy[r];
      end
    end
    busy_next[0] = 1'b0;
  end

  // Busy vector, its population count and the collision pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= {DEPTH{1'b0}};
      busyCnt     <= {(ADDR_W+1){1'b0}};
      wrCollision <= 1'b0;
    end else begin
      busy        <= busy_next;
      busyCnt     <= popcount(busy_next);
      wrCollision <= wr0_ok && wr1_ok && (wrAddr0 == wrAddr1);
    end
  end

  // Read ports; outputs are forced quiet while reset is held
  always_comb begin
    readData = {(NREAD*DATA_W){1'b0}};
    readBusy = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      logic [ADDR_W-1:0] a;
      logic              hit0;
      logic              hit1;
      logic              iss;
      a    = readAddr[k*ADDR_W +: ADDR_W];
      hit0 = BYP && wr0_ok && (wrAddr0 == a);
      hit1 = BYP && wr1_ok && (wrAddr1 == a);
      iss  = issueEn && (issueAddr == a);
      if (!rst_n || (a == {ADDR_W{1'b0}})) begin
        readData[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        readBusy[k]                  = 1'b0;
      end else begin
        if (hit1) begin
          readData[k*DATA_W +: DATA_W] = wrData1;
        end else if (hit0) begin
          readData[k*DATA_W +: DATA_W] = wrData0;
        end else begin
          readData[k*DATA_W +: DATA_W] = regs[a];
        end
        if ((hit0 || hit1) && !iss) begin
          readBusy[k] = 1'b0;
        end else begin
          readBusy[k] = busy[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with forwarding, one without,
// driven by the same stimulus and checked against hand-computed values.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  readAddr;
  logic        wrEn0, wrEn1, issueEn, flush;
  logic [4:0]  wrAddr0, wrAddr1, issueAddr;
  logic [31:0] wrData0, wrData1;

  logic [63:0] rd_b1, rd_b0;
  logic [1:0]  rb_b1, rb_b0;
  logic        col_b1, col_b0;
  logic [5:0]  cnt_b1, cnt_b0;

  int total = 0;
  int bad   = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .readAddr(readAddr), .readData(rd_b1), .readBusy(rb_b1),
    .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .issueEn(issueEn), .issueAddr(issueAddr), .flush(flush),
    .wrCollision(col_b1), .busyCnt(cnt_b1)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .readAddr(readAddr), .readData(rd_b0), .readBusy(rb_b0),
    .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .issueEn(issueEn), .issueAddr(issueAddr), .flush(flush),
    .wrCollision(col_b0), .busyCnt(cnt_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wrEn0 = 1'b0; wrEn1 = 1'b0; issueEn = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    wrEn0 = 1'b1; wrAddr0 = a; wrData0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    wrEn1 = 1'b1; wrAddr1 = a; wrData1 = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issueEn = 1'b1; issueAddr = a;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    readAddr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wrAddr0 = 5'd0; wrAddr1 = 5'd0; issueAddr = 5'd0;
    wrData0 = 32'h0; wrData1 = 32'h0;
    rd(5'd0, 5'd0);
    #2;
    chk("reset_cnt", {26'd0, cnt_b1}, 32'd0);
    chk("reset_col", {31'd0, col_b1}, 32'd0);
    tick();
    #2 rst_n = 1'b1;

    // Register 0 is never written or marked busy
    tick();
    wr0(5'd0, 32'hFFFF_FFFF); issue(5'd0); rd(5'd0, 5'd0);
    #1;
    chk("r0_bypass_data", rd_b1[31:0], 32'h0);
    chk("r0_bypass_busy", {30'd0, rb_b1}, 32'd0);
    tick();
    idle();
    #1;
    chk("r0_data", rd_b1[31:0], 32'h0);
    chk("r0_busy", {30'd0, rb_b1}, 32'd0);
    chk("r0_cnt", {26'd0, cnt_b1}, 32'd0);

    // Same-cycle forwarding versus array-only read
    wr0(5'd7, 32'h1234_5678); rd(5'd7, 5'd0);
    #1;
    chk("byp1_same", rd_b1[63:32], 32'h1234_5678);
    chk("byp0_same", rd_b0[63:32], 32'h0);
    tick();
    idle();
    #1;
    chk("byp0_next", rd_b0[63:32], 32'h1234_5678);
    chk("byp1_next", rd_b1[63:32], 32'h1234_5678);

    // Both ports to r3: port 1 wins, one-cycle collision pulse
    wr0(5'd3, 32'hAAAA_0000); wr1(5'd3, 32'h5555_FFFF); rd(5'd0, 5'd3);
    #1;
    chk("coll_byp", rd_b1[31:0], 32'h5555_FFFF);
    tick();
    idle();
    #1;
    chk("coll_pulse", {31'd0, col_b1}, 32'd1);
    chk("coll_pulse_b0", {31'd0, col_b0}, 32'd1);
    chk("coll_data", rd_b0[31:0], 32'h5555_FFFF);
    tick();
    chk("coll_end", {31'd0, col_b1}, 32'd0);

    // Both ports to r0 do not collide; distinct addresses both land
    wr0(5'd0, 32'h1); wr1(5'd0, 32'h2);
    tick();
    idle();
    #1;
    chk("coll_r0", {31'd0, col_b1}, 32'd0);
    wr0(5'd11, 32'h1111_1111); wr1(5'd12, 32'h2222_2222);
    tick();
    idle();
    rd(5'd12, 5'd11);
    #1;
    chk("dual_col", {31'd0, col_b1}, 32'd0);
    chk("dual_p0", rd_b0[31:0], 32'h1111_1111);
    chk("dual_p1", rd_b0[63:32], 32'h2222_2222);

    // Scoreboard: issue r9 then r10
    issue(5'd9); rd(5'd10, 5'd9);
    tick();
    idle();
    #1;
    chk("sb_cnt1", {26'd0, cnt_b1}, 32'd1);
    chk("sb_busy9", {30'd0, rb_b1}, 32'd1);
    issue(5'd10);
    tick();
    idle();
    #1;
    chk("sb_cnt2", {26'd0, cnt_b1}, 32'd2);
    wr1(5'd9, 32'h0000_0099);
    #1;
    chk("sb_wclr_b1", {30'd0, rb_b1}, 32'd2);
    chk("sb_wclr_b0", {30'd0, rb_b0}, 32'd3);
    tick();
    idle();
    #1;
    chk("sb_cnt_after_wr", {26'd0, cnt_b1}, 32'd1);
    chk("sb_busy_after_wr", {30'd0, rb_b0}, 32'd2);
    issue(5'd10); wr0(5'd10, 32'h0000_0010);
    #1;
    chk("sb_iss_wr_same", {30'd0, rb_b1}, 32'd2);
    tick();
    idle();
    #1;
    chk("sb_iss_wins_cnt", {26'd0, cnt_b1}, 32'd1);
    chk("sb_iss_wins_busy", {30'd0, rb_b1}, 32'd2);

    // Flush with a same-cycle issue and write
    issue(5'd2); tick(); issue(5'd4); tick(); issue(5'd6); tick();
    idle();
    #1;
    chk("fl_pre_cnt", {26'd0, cnt_b1}, 32'd4);
    flush = 1'b1; issue(5'd8); wr0(5'd4, 32'h0000_0044);
    tick();
    idle();
    rd(5'd8, 5'd2);
    #1;
    chk("fl_cnt", {26'd0, cnt_b1}, 32'd0);
    chk("fl_busy", {30'd0, rb_b1}, 32'd0);
    rd(5'd10, 5'd4);
    #1;
    chk("fl_busy10", {30'd0, rb_b0}, 32'd0);
    chk("fl_write", rd_b0[31:0], 32'h0000_0044);

    // Asynchronous reset mid-operation
    wr0(5'd5, 32'hDEAD_BEEF); issue(5'd13);
    tick();
    idle();
    rd(5'd6, 5'd5);
    #1;
    chk("rst_pre_data", rd_b0[31:0], 32'hDEAD_BEEF);
    chk("rst_pre_cnt", {26'd0, cnt_b1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", rd_b1[31:0], 32'h0);
    chk("rst_cnt", {26'd0, cnt_b1}, 32'd0);
    chk("rst_col", {31'd0, col_b1}, 32'd0);
    wr0(5'd6, 32'h0000_0066); issue(5'd6);
    tick();
    tick();
    idle();
    wr1(5'd14, 32'h0000_1414);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_no_capture", rd_b0[63:32], 32'h0);
    tick();
    idle();
    rd(5'd14, 5'd6);
    #1;
    chk("rst_first_edge", rd_b0[63:32], 32'h0000_1414);
    chk("rst_no_wr", rd_b0[31:0], 32'h0);
    chk("rst_no_busy", {26'd0, cnt_b0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with a built-in pending-write scoreboard for the pipelined MIPS core. It sits between decode (read ports, issue/busy tracking) and writeback (two write ports: ALU path and load/multiply path). It provides same-cycle write-to-read bypass and per-register busy flags for hazard detection. The datapath is hardwired-zero for register 0.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy flags; 0 = array value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- readAddr  in  NREAD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- readData  out  NREAD*DATA_W  read data, combinational, packed like readAddr
- readBusy  out  NREAD  1 = register at readAddr[k] has an outstanding producer
- wrEn0 / wrAddr0 / wrData0  in  1 / ADDR_W / DATA_W  write port 0 (ALU writeback)
- wrEn1 / wrAddr1 / wrData1  in  1 / ADDR_W / DATA_W  write port 1 (load/mult writeback)
- issueEn  in  1  instruction issued with destination issueAddr
- issueAddr  in  ADDR_W  destination register of issued instruction
- flush  in  1  clear all busy bits (pipeline flush)
- wrCollision  out  1  registered 1-cycle pulse: both ports wrote the same non-zero address last cycle
- busyCnt  out  ADDR_W+1  registered count of set busy bits

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, wrCollision 0, busyCnt 0. Outputs readData = 0, readBusy = 0 while reset is held.
- Register 0: writes discarded, never marked busy, reads always return 0, readBusy always 0.
- Writes: on rising edge, wrEnK with non-zero wrAddrK stores wrDataK. Both ports to same address: port 1 wins; wrCollision = 1 in the following cycle only.
- Reads: readData[k] = 0 if address 0; else if BYPASS and a write to that address is enabled this cycle, the winning write data (port 1 over port 0); else array contents.
- Scoreboard next-state per register r (r != 0), in priority order:
  - flush: busy[r] = 0 (issueEn ignored this cycle; writes still update the array)
  - issueEn and issueAddr == r: busy[r] = 1 (set wins over a same-cycle write to r)
  - write on either port to r: busy[r] = 0
  - else hold
- readBusy[k] = busy[readAddr[k]]; if BYPASS, forced 0 when a write to that address is enabled this cycle and no same-cycle issue targets it.
- busyCnt = popcount of the busy vector, updated on the same edge as the vector; never exceeds 2**ADDR_W - 1.

## Timing
- Write latency: data in the array at the edge after wrEn; with BYPASS=1 it is visible on readData combinationally in the same cycle; with BYPASS=0 from the next cycle.
- Read path is purely combinational from readAddr/write ports; no read latency.
- Busy set by issueEn is visible on readBusy from the next cycle.
- wrCollision and busyCnt are registered: one cycle after the causing edge.
- Reset deasserted mid-operation: the first rising edge after rst_n goes high performs normal updates; no writes or issues are captured while rst_n is low.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 asynchronously between edges -> readData r5 = 0 immediately, busyCnt = 0, wrCollision = 0.
- Zero register: wrEn0 to r0 with 0xFFFFFFFF, issueEn to r0 -> readData r0 = 0, readBusy = 0, busyCnt = 0.
- Bypass: BYPASS=1, wrEn0 r7 = 0x12345678 while readAddr port1 = r7 -> readData = 0x12345678 in the same cycle; BYPASS=0 -> old value 0, new value next cycle.
- Collision: wrEn0 r3 = 0xAAAA0000 and wrEn1 r3 = 0x5555FFFF in the same cycle -> r3 = 0x5555FFFF, wrCollision = 1 for exactly one cycle.
- Scoreboard: issue r9, then r10 -> busyCnt 1 then 2; write r9 on port 1 -> readBusy(r9) = 0 in the same cycle (BYPASS=1), busyCnt = 1 next cycle; issue r10 and write r10 in the same cycle -> r10 stays busy.
- Flush: busy r2, r4, r6, then flush together with issueEn r8 -> all busy bits 0, busyCnt = 0, r8 not busy.
